// File: rtl/disparity_pkg.sv
// Shared encodings for the stereo disparity subsystem: frame sequencer states,
// disparity core states (both shown on LEDs) and sequencer defaults.
package disparity_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_SWAP      = 3'd5
    } frame_state_t;

    typedef enum logic [2:0] {
        CORE_IDLE     = 3'd0,
        CORE_READ     = 3'd1,
        CORE_SEPARATE = 3'd2,
        CORE_SAD      = 3'd3,
        CORE_FINALIZE = 3'd4
    } core_state_t;

endpackage

// File: rtl/disparity_frame_ctrl_if.sv
// Capture front-end and disparity core handshake seen by the frame sequencer.
interface disparity_frame_ctrl_if;

    logic cap_done_l;
    logic cap_done_r;
    logic cap_arm;
    logic disp_idle;
    logic disp_enable;
    logic buffer_ready;

    modport master (
        input  cap_done_l, cap_done_r, disp_idle,
        output cap_arm, disp_enable, buffer_ready
    );

    modport slave (
        output cap_done_l, cap_done_r, disp_idle,
        input  cap_arm, disp_enable, buffer_ready
    );

endinterface

// File: rtl/disparity_frame_ctrl_watchdog.sv
// Cycle watchdog: counts while enabled, flags the cycle the count reaches LIMIT-1.
module watchdog_counter
    import disparity_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_count;

    assign o_terminal = i_enable && (r_count == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/disparity_frame_ctrl.sv
// Frame sequencer: arm capture, wait for both frames, start the disparity core,
// wait for it to finish, then swap the displayed result bank.
module disparity_frame_ctrl
    import disparity_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 single,
    disparity_frame_ctrl_if.master ctl,
    output logic                 bank_sel,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [2:0]           state_out
);

    frame_state_t r_state;
    frame_state_t w_next;
    logic         r_got_l;
    logic         r_got_r;
    logic         w_wd_clear;
    logic         w_wd_en;
    logic         w_timeout;

    assign w_wd_clear = (r_state == ST_START);
    assign w_wd_en    = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);

    watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_wd_clear),
        .i_enable   (w_wd_en),
        .o_terminal (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (run || single) w_next = ST_CAPTURE;
            ST_CAPTURE:   if ((r_got_l || ctl.cap_done_l) && (r_got_r || ctl.cap_done_r))
                              w_next = ST_START;
            ST_START:     w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!ctl.disp_idle) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (ctl.disp_idle) w_next = ST_SWAP;
            ST_SWAP:      w_next = run ? ST_CAPTURE : ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
        // Watchdog abort wins over a same-cycle engine completion.
        if (w_timeout) begin
            w_next = ST_IDLE;
        end
    end

    assign ctl.cap_arm      = (r_state == ST_CAPTURE);
    assign ctl.disp_enable  = (r_state == ST_START);
    assign ctl.buffer_ready = (r_state == ST_START) || (r_state == ST_WAIT_BUSY) ||
                              (r_state == ST_WAIT_DONE);
    assign busy             = (r_state != ST_IDLE);
    assign state_out        = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_got_l     <= 1'b0;
            r_got_r     <= 1'b0;
            bank_sel    <= 1'b0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Flags only live while capturing, so every CAPTURE entry starts clean.
            if (r_state == ST_CAPTURE) begin
                r_got_l <= r_got_l | ctl.cap_done_l;
                r_got_r <= r_got_r | ctl.cap_done_r;
            end else begin
                r_got_l <= 1'b0;
                r_got_r <= 1'b0;
            end
            if (r_state == ST_SWAP) begin
                bank_sel    <= ~bank_sel;
                frame_count <= frame_count + 1'b1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disparity_frame_ctrl.sv
// Self-checking bench for disparity_frame_ctrl: randomized frame timing against
// a frame-level model of expected start/swap cycles, counters and error flag.
module tb_disparity_frame_ctrl;

    localparam int unsigned TO = 64;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          single;
    logic          bank_sel;
    logic [CW-1:0] frame_count;
    logic          busy;
    logic          timeout_err;
    logic [2:0]    state_out;

    disparity_frame_ctrl_if u_if ();

    disparity_frame_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .single      (single),
        .ctl         (u_if),
        .bank_sel    (bank_sel),
        .frame_count (frame_count),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          cyc   = 0;
    int          exp_cnt  = 0;
    int          exp_bank = 0;
    int          exp_err  = 0;
    bit          mon_on   = 1'b0;
    logic        prev_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_status();
        check("frame_count", frame_count, exp_cnt);
        check("bank_sel", bank_sel, exp_bank);
        check("timeout_err", timeout_err, exp_err);
    endtask

    task automatic pulse_single();
        check("idle_before_single", state_out, 0);
        single = 1'b1;
        tick();
        single = 1'b0;
    endtask

    // mode 0: normal, 1: engine never starts, 2: engine never finishes,
    // 3: reset asserted while waiting for the engine to finish
    task automatic frame(input bit simul, input int pre, input int gap, input int extra_l,
                         input int lat, input int len, input bit drop_run, input int mode);
        check("cap_arm_on", u_if.cap_arm, 1);
        check("state_capture", state_out, 1);
        ticks(pre);
        if (simul) begin
            u_if.cap_done_l = 1'b1;
            u_if.cap_done_r = 1'b1;
            tick();
            u_if.cap_done_l = 1'b0;
            u_if.cap_done_r = 1'b0;
        end else begin
            u_if.cap_done_l = 1'b1;
            tick();
            u_if.cap_done_l = 1'b0;
            check("left_only_no_start", u_if.disp_enable, 0);
            check("left_only_state", state_out, 1);
            for (int i = 0; i < extra_l; i++) begin
                tick();
                u_if.cap_done_l = 1'b1;
                tick();
                u_if.cap_done_l = 1'b0;
                check("repeat_left_no_start", u_if.disp_enable, 0);
            end
            ticks(gap);
            u_if.cap_done_r = 1'b1;
            tick();
            u_if.cap_done_r = 1'b0;
        end
        check("start_enable", u_if.disp_enable, 1);
        check("start_cap_arm_off", u_if.cap_arm, 0);
        check("start_buffer_ready", u_if.buffer_ready, 1);
        check("start_state", state_out, 2);
        check("start_busy", busy, 1);
        tick();
        check("wait_busy_enable_off", u_if.disp_enable, 0);
        check("wait_busy_state", state_out, 3);
        if (mode == 1) begin
            ticks(TO - 1);
            check("to_last_cycle_state", state_out, 3);
            check("to_last_cycle_err", timeout_err, exp_err);
            tick();
            exp_err = 1;
            check("to_state_idle", state_out, 0);
            check_status();
            return;
        end
        ticks(lat);
        check("wait_busy_hold", state_out, 3);
        u_if.disp_idle = 1'b0;
        if (mode == 2) begin
            ticks(TO - 1 - lat);
            check("to2_last_cycle_state", state_out, 4);
            tick();
            exp_err = 1;
            u_if.disp_idle = 1'b1;
            check("to2_state_idle", state_out, 0);
            check_status();
            return;
        end
        ticks(len);
        check("wait_done_state", state_out, 4);
        check("wait_done_ready", u_if.buffer_ready, 1);
        if (mode == 3) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            u_if.disp_idle = 1'b1;
            exp_cnt = 0; exp_bank = 0; exp_err = 0;
            check("rst_state", state_out, 0);
            check("rst_cap_arm", u_if.cap_arm, 0);
            check("rst_enable", u_if.disp_enable, 0);
            check("rst_ready", u_if.buffer_ready, 0);
            check("rst_busy", busy, 0);
            check_status();
            return;
        end
        if (drop_run) run = 1'b0;
        u_if.disp_idle = 1'b1;
        tick();
        check("swap_state", state_out, 5);
        check_status();
        exp_bank ^= 1;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        tick();
        check_status();
        check("after_swap_state", state_out, run ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("arm_ready_exclusive", u_if.cap_arm & u_if.buffer_ready, 0);
            check("enable_single_cycle", prev_en & u_if.disp_enable, 0);
            prev_en = u_if.disp_enable;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; single = 1'b0;
        u_if.cap_done_l = 1'b0;
        u_if.cap_done_r = 1'b0;
        u_if.disp_idle  = 1'b1;
        ticks(2);
        check("reset_state", state_out, 0);
        check("reset_cap_arm", u_if.cap_arm, 0);
        check("reset_enable", u_if.disp_enable, 0);
        check("reset_ready", u_if.buffer_ready, 0);
        check("reset_busy", busy, 0);
        check_status();
        reset = 1'b0;
        tick();
        mon_on = 1'b1;

        // Directed: left done 10 cycles in, right 10 later, core busy 50 cycles.
        pulse_single();
        frame(1'b0, 9, 9, 0, 0, 50, 1'b0, 0);
        ticks(3);
        check("directed_idle", state_out, 0);

        for (int i = 0; i < 8; i++) begin
            pulse_single();
            frame(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 6),
                  $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(1, 20), 1'b0, 0);
            ticks($urandom_range(0, 3));
        end

        // Continuous mode: three frames, run dropped during the third.
        run = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            frame(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(1, 10),
                  (i == 2), 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_run_no_arm", u_if.cap_arm, 0);
        end

        // Watchdog: engine never leaves idle, then a normal frame, then stuck busy.
        pulse_single();
        frame(1'b1, 2, 0, 0, 0, 0, 1'b0, 1);
        ticks(2);
        pulse_single();
        frame(1'b0, 3, 2, 1, 1, 5, 1'b0, 0);
        pulse_single();
        frame(1'b1, 1, 0, 0, $urandom_range(0, 40), 0, 1'b0, 2);
        ticks(1);
        pulse_single();
        frame(1'b1, 0, 0, 0, 0, 1, 1'b0, 0);

        // Reset while the core is running.
        pulse_single();
        frame(1'b0, 2, 3, 0, $urandom_range(0, 4), $urandom_range(1, 10), 1'b0, 3);
        tick();
        pulse_single();
        frame(1'b1, 1, 0, 0, 2, 4, 1'b0, 0);

        ticks(2);
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/disparity_frame_ctrl.md
# disparity_frame_ctrl

Frame-level sequencer for the stereo disparity engine. It arms the left/right capture blocks and waits for both frames. It then freezes the image buffers and pulses the engine's start, and waits for the engine to finish. Finally it swaps the result bank seen by the display reader. It sits between the two camera capture front-ends, the `disparity` core and the VGA result scanner, and runs one frame at a time or continuously.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 2000000: maximum cycles spent in WAIT_BUSY plus WAIT_DONE before abort.
- `CNT_W`, 16: width of `frame_count`.

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; continuous mode while high.
- `single`  in  1  pulse; request one frame; ignored unless state is IDLE.
- `cap_done_l`  in  1  one-cycle pulse: left capture frame complete.
- `cap_done_r`  in  1  one-cycle pulse: right capture frame complete.
- `cap_arm`  out  1  capture blocks may write image buffers.
- `disp_idle`  in  1  `idle` output of the disparity core.
- `disp_enable`  out  1  one-cycle start pulse to the core's `enable`.
- `buffer_ready`  out  1  image buffers are stable and valid for the core.
- `bank_sel`  out  1  result bank presented to the display.
- `frame_count`  out  CNT_W  completed frames, wraps.
- `busy`  out  1  state != IDLE.
- `timeout_err`  out  1  sticky abort flag.
- `state_out`  out  3  current state encoding, for LEDs.

## Operation
- States: IDLE=0, CAPTURE=1, START=2, WAIT_BUSY=3, WAIT_DONE=4, SWAP=5. Codes 6 and 7 go to IDLE.
- **IDLE**
  - `run` or `single` high → CAPTURE.
  - On entry to CAPTURE, clear the capture flags `got_l` and `got_r`.
- **CAPTURE**
  - `cap_arm`=1.
  - `got_l` and `got_r` set on their done pulses. Simultaneous pulses are legal.
  - Next state = START when (`got_l`|`cap_done_l`)&(`got_r`|`cap_done_r`).
  - Done pulses outside CAPTURE are ignored.
- **START**
  - `disp_enable`=1 for exactly this one cycle.
  - → WAIT_BUSY.
- **WAIT_BUSY**
  - Wait for `disp_idle`=0.
  - → WAIT_DONE.
- **WAIT_DONE**
  - Wait for `disp_idle`=1.
  - → SWAP.
- **SWAP**
  - Toggle `bank_sel`.
  - `frame_count`+1, wrapping from all-ones to 0.
  - → CAPTURE if `run`, else IDLE.
- `buffer_ready`=1 in START, WAIT_BUSY and WAIT_DONE; 0 otherwise.
  - `cap_arm` and `buffer_ready` are never high together.
- Watchdog:
  - Counter cleared on entry to WAIT_BUSY.
  - Increments each cycle in WAIT_BUSY and WAIT_DONE.
  - At `TIMEOUT_CYCLES`-1:
    - `timeout_err` is set.
    - State → IDLE.
    - No bank swap, no count increment.
- `timeout_err` is cleared only by `reset`. It does not block further runs.
- `run` dropping mid-frame: the current frame completes through SWAP, then → IDLE.

## Timing
- All outputs are registered or are Moore decodes of the state register. No combinational path from any input to any output.
- Reset values:
  - State IDLE.
  - `cap_arm`, `disp_enable`, `buffer_ready`, `busy`, `timeout_err`, `bank_sel` = 0.
  - `frame_count` = 0.
  - `state_out` = 0.
- `reset` asserted in any state takes effect on that edge. `disp_enable` is low the following cycle.
- `run` sampled at edge n → `cap_arm`=1 from cycle n+1.
- Final done pulse sampled at edge n → `disp_enable`=1 in cycle n+1 only. `cap_arm` falls in the same cycle.
- Minimum engine handshake: `disp_idle` low for one cycle gives SWAP 3 cycles after START.
- `bank_sel` and `frame_count` change in the cycle after SWAP, i.e. on the edge leaving SWAP.

## Structure
- Shared package `disparity_pkg` holds:
  - state encoding constants;
  - `TIMEOUT_CYCLES` default;
  - the core's state codes (IDLE/READ/SEPARATE/SAD/FINALIZE), so both LED encodings live in one place.
- One sub-module, `watchdog_counter`: clear, enable, terminal-count output, parameterised by limit.
- Expected size: FSM plus flags roughly 150–200 lines.

## Test plan
- Pulse `single`, then `cap_done_l` at cycle 10 and `cap_done_r` at cycle 20, with a core model busy for 50 cycles → exactly one `disp_enable` pulse at cycle 21; `bank_sel`=1; `frame_count`=1; back in IDLE.
- Simultaneous `cap_done_l`/`cap_done_r` → START on the next cycle. Repeated `cap_done_l` pulses before `cap_done_r` → still one start.
- `run` held high for 3 frames, dropped during the 3rd frame's WAIT_DONE → `frame_count`=3, `bank_sel`=1, ends in IDLE, no 4th `cap_arm`.
- `TIMEOUT_CYCLES`=64 with `disp_idle` stuck high → `timeout_err`=1 after 64 cycles in WAIT_BUSY; IDLE; `frame_count` and `bank_sel` unchanged. Next `single` runs normally and `timeout_err` stays 1.
- `reset` asserted in WAIT_DONE → all outputs at reset values the next cycle, `frame_count`=0.
- Check every cycle: `cap_arm` & `buffer_ready` never both high; `disp_enable` never high for two consecutive cycles.
